gamma_cycle_controller: RTL



---
 rtl/gamma_ctrl_pkg.sv | 22 ++
 rtl/first_arrival_capture.sv | 37 +++
 rtl/gamma_cycle_controller.sv | 127 ++++++++++++
 3 files changed

// File: rtl/gamma_ctrl_pkg.sv
// Shared types and helpers for the gamma-cycle controller.
package gamma_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CLEAR,
    WINDOW,
    REPORT
  } state_t;

  // Bits needed to count 0..n-1 (at least one bit).
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // A lane that never fires reports the window length as its time,
  // a saturated "infinity" that no real timestamp can reach.
  function automatic int unsigned no_fire_time(input int unsigned len);
    return len;
  endfunction

endpackage

// File: rtl/first_arrival_capture.sv
// Per-lane first-rising-edge timestamp capture for one exclusive-min output.
module first_arrival_capture #(
  parameter int unsigned W = 16
) (
  input  logic         aclk,
  input  logic         grst_n,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] t,
  input  logic         q,
  output logic [W-1:0] cap_time,
  output logic         fired
);

  logic prev;

  // Clear loads t as the no-fire value and forces prev low so a lane that is
  // already high on the first window cycle registers as an edge at t=0.
  always_ff @(posedge aclk) begin
    if (!grst_n) begin
      prev     <= 1'b0;
      cap_time <= '0;
      fired    <= 1'b0;
    end else if (clr) begin
      prev     <= 1'b0;
      cap_time <= t;
      fired    <= 1'b0;
    end else if (en) begin
      prev <= q;
      if (q && !prev && !fired) begin
        cap_time <= t;
        fired    <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/gamma_cycle_controller.sv
// Gamma-cycle sequencer for an array of exclusive-min race-logic units:
// clears the units, runs a timed window, timestamps first arrivals and
// hands the per-lane results out over a valid/ready port.
module gamma_cycle_controller
  import gamma_ctrl_pkg::*;
#(
  parameter int unsigned GAMMA_CYCLE_WIDTH = 16,
  parameter int unsigned NUM_LANES         = 4,
  parameter int unsigned RST_CYCLES        = 2
) (
  input  logic                                   aclk,
  input  logic                                   grst_n,
  input  logic                                   start,
  input  logic                                   stop,
  input  logic [GAMMA_CYCLE_WIDTH-1:0]           cfg_gamma_len,
  input  logic [NUM_LANES-1:0]                   lane_q,
  output logic                                   unit_rst,
  output logic                                   gamma_tick,
  output logic                                   busy,
  output logic [GAMMA_CYCLE_WIDTH-1:0]           gamma_count,
  output logic                                   res_valid,
  input  logic                                   res_ready,
  output logic [NUM_LANES*GAMMA_CYCLE_WIDTH-1:0] res_time,
  output logic [NUM_LANES-1:0]                   res_fired
);

  localparam int unsigned W  = GAMMA_CYCLE_WIDTH;
  localparam int unsigned CW = cnt_width(RST_CYCLES);
  localparam logic [CW-1:0] RST_LAST = CW'(RST_CYCLES - 1);

  state_t         state;
  state_t         state_next;
  logic [CW-1:0]  rst_cnt;
  logic [W-1:0]   t_cnt;
  logic [W-1:0]   t_last;
  logic [W-1:0]   len_q;
  logic [W-1:0]   lane_t;
  logic           stop_pending;
  logic           handshake;
  logic           lane_clr;
  logic           lane_en;

  assign t_last    = len_q - W'(1);
  assign handshake = (state == REPORT) && res_ready;
  assign lane_clr  = (state == CLEAR);
  assign lane_en   = (state == WINDOW);
  // Outside the window the lane time bus carries the no-fire value, which
  // the capture cells load while being cleared.
  assign lane_t    = lane_en ? t_cnt : W'(no_fire_time(32'(len_q)));

  // State register.
  always_ff @(posedge aclk) begin
    if (!grst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = CLEAR;
      CLEAR:   if (rst_cnt == RST_LAST) state_next = WINDOW;
      WINDOW:  if (t_cnt == t_last) state_next = REPORT;
      REPORT:  if (res_ready) state_next = stop_pending ? IDLE : CLEAR;
      default: state_next = IDLE;
    endcase
  end

  // Length latch, phase counters, stop request and completed-cycle count.
  always_ff @(posedge aclk) begin
    if (!grst_n) begin
      len_q        <= W'(1);
      rst_cnt      <= '0;
      t_cnt        <= '0;
      stop_pending <= 1'b0;
      gamma_count  <= '0;
    end else begin
      if ((state == IDLE) && start) begin
        len_q <= (cfg_gamma_len == '0) ? W'(1) : cfg_gamma_len;
      end
      rst_cnt <= (state == CLEAR)  ? rst_cnt + CW'(1) : '0;
      t_cnt   <= (state == WINDOW) ? t_cnt + W'(1)    : '0;
      if (handshake) begin
        gamma_count <= gamma_count + W'(1);
      end
      if (handshake && stop_pending) begin
        stop_pending <= 1'b0;
      end else if (stop && ((state != IDLE) || start)) begin
        stop_pending <= 1'b1;
      end
    end
  end

  // Status outputs registered from the next state so they align with it.
  always_ff @(posedge aclk) begin
    if (!grst_n) begin
      unit_rst   <= 1'b1;
      gamma_tick <= 1'b0;
      busy       <= 1'b0;
      res_valid  <= 1'b0;
    end else begin
      unit_rst   <= (state_next == IDLE) || (state_next == CLEAR);
      gamma_tick <= (state_next == WINDOW) && (state != WINDOW);
      busy       <= (state_next != IDLE);
      res_valid  <= (state_next == REPORT);
    end
  end

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    first_arrival_capture #(
      .W(W)
    ) u_cap (
      .aclk     (aclk),
      .grst_n   (grst_n),
      .clr      (lane_clr),
      .en       (lane_en),
      .t        (lane_t),
      .q        (lane_q[i]),
      .cap_time (res_time[i*W +: W]),
      .fired    (res_fired[i])
    );
  end

endmodule
